input_debouncer: RTL
====================

// Module: input_debouncer
// PURPOSE
//  Upstream conditioning stage for the gate-level combinational blocks (AndGate et al.).
//  Takes WIDTH raw asynchronous switch/button inputs and synchronises each to clk.
//  Debounces each input and presents clean, glitch-free levels (data_o[0]->a, data_o[1]->b).
//  Also emits one-cycle rise/fall pulses per channel for downstream event logic.
// PARAMETERS
//  WIDTH          2  number of independent input channels
//  SYNC_STAGES    2  synchroniser flops per channel (>=2)
//  STABLE_CYCLES  4  consecutive qualifying ticks a new level must persist before acceptance (>=1)
// PORTS
//  clk      in   1      single system clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  raw_i    in   WIDTH  raw asynchronous inputs
//  tick_i   in   1      debounce sample enable (tie 1 for per-clock counting)
//  data_o   out  WIDTH  debounced stable levels
//  rise_o   out  WIDTH  1-cycle pulse: data_o[n] went 0->1 this cycle
//  fall_o   out  WIDTH  1-cycle pulse: data_o[n] went 1->0 this cycle
//  busy_o   out  WIDTH  channel n has a pending (unconfirmed) change, i.e. count != 0
// BEHAVIOUR
//  - Reset (async assert, sync deassert by design): sync flops, counters, data_o, rise_o, fall_o, busy_o all 0.
//  - Per channel: sync_n = last stage of SYNC_STAGES flop chain sampling raw_i[n].
//  - Counter cnt, width $clog2(STABLE_CYCLES+1), per channel; evaluated each clk edge:
//    * sync_n == data_o[n]                            -> cnt <= 0 (regardless of tick_i)
//    * sync_n != data_o[n], tick_i=0                  -> cnt holds
//    * sync_n != data_o[n], tick_i=1, cnt<STABLE_CYCLES-1 -> cnt <= cnt+1
//    * sync_n != data_o[n], tick_i=1, cnt==STABLE_CYCLES-1 -> data_o[n] <= sync_n, cnt <= 0,
//      rise_o[n]/fall_o[n] <= 1 for exactly that cycle (registered, coincident with data_o change)
//  - rise_o/fall_o are 0 in every other cycle; never both 1 on one channel.
//  - Latency (tick_i=1): raw change first sampled at edge k -> data_o changes at edge k+SYNC_STAGES+STABLE_CYCLES-1.
//  - Glitch rejection: any return of sync_n to data_o[n] before acceptance clears cnt; pulse shorter than
//    STABLE_CYCLES ticks (after sync) never reaches data_o.
//  - Channels fully independent; simultaneous changes on several channels accepted in the same cycle.
//  - Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.
//  - Reset mid-count: pending change discarded, data_o returns to 0; a raw input held at 1 through reset
//    is re-qualified and accepted SYNC_STAGES+STABLE_CYCLES-1 edges after the first post-reset sampling edge.
//  - Per-channel FSM (implicit in data_o/cnt): STABLE_LO -> PEND_HI -> STABLE_HI -> PEND_LO -> STABLE_LO;
//    PEND_* falls back to the prior STABLE_* on glitch.
// STRUCTURE
//  - Shared package debounce_pkg: default constants (DEF_SYNC_STAGES=2, DEF_STABLE_CYCLES=4) and
//    function cnt_width(stable_cycles) returning $clog2(stable_cycles+1).
//  - Sub-module debounce_channel (1 bit: sync chain + counter + pulse regs), instantiated WIDTH times via generate.
//  - No combinational path from raw_i or tick_i to any output.
// TESTING
//  Bench instantiates input_debouncer feeding AndGate (a=data_o[0], b=data_o[1]) with defaults, 10 ns clk,
//  and monitors data_o, rise_o, fall_o, y.
//  1 Reset: rst_n=0 with raw_i=2'b11 -> all outputs 0; release rst_n -> data_o=2'b11 at the 6th edge
//    after release (first edge samples), rise_o=2'b11 for exactly that one cycle.
//  2 Clean step: raw_i 00->01 held -> data_o[0]=1 at 6th edge, rise_o[0] one cycle, AndGate y stays 0;
//    then raw_i=11 -> y=1 six edges later.
//  3 Glitch: raw_i[1] high for 3 clk cycles then low -> data_o, rise_o, fall_o unchanged; busy_o[1] pulses high.
//  4 Bounce: raw_i[0] toggles 1,0,1,0,1 per cycle then held 1 -> one rise_o[0] pulse only,
//    4 stable ticks after the last sync transition.
//  5 Tick gating: tick_i high every 3rd cycle, raw_i[0] 0->1 -> acceptance after 4 ticks;
//    a mismatch with tick_i low leaves cnt frozen.
//  6 Reset mid-count: assert rst_n after cnt=2 pending on channel 0 -> data_o=0, no rise_o;
//    post-reset requalification timing identical to scenario 1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the input debouncer and its channels.
package debounce_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

    // Counter must hold 0..STABLE_CYCLES-1 with headroom so the terminal value is representable.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: synchroniser chain, stability counter and registered edge pulses.
// The channel state (STABLE_LO/PEND_HI/STABLE_HI/PEND_LO) is implicit in data_q and cnt_q.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   data_q, data_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Any agreement with the accepted level cancels a pending change, tick or not.
        if (sync_s == data_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                data_d = sync_s;
                cnt_d  = '0;
                rise_d = sync_s;
                fall_d = ~sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            data_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/input_debouncer.sv
// WIDTH independent debounce channels; every output is registered or decoded from registers only.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    input  logic             tick_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] busy_o
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw_i (raw_i[g]),
            .tick_i(tick_i),
            .data_o(data_o[g]),
            .rise_o(rise_o[g]),
            .fall_o(fall_o[g]),
            .busy_o(busy_o[g])
        );
    end

endmodule
